// File: rtl/alu_seq_unit_if.sv
// Request/result handshake bundle between a requester and the sequential ALU unit.
interface alu_seq_unit_if #(parameter int WIDTH = 8);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [2:0]       opcode;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry;
  logic             zero;

  modport master (
    output req_valid, opA, opB, opcode, res_ready,
    input  req_ready, res_valid, result, result_hi, carry, zero
  );

  modport slave (
    input  req_valid, opA, opB, opcode, res_ready,
    output req_ready, res_valid, result, result_hi, carry, zero
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle logic/arithmetic/shift ops and an 8-step shift-add multiply,
// with valid/ready handshakes on both the request and result sides.
module alu_seq_unit #(parameter int WIDTH = 8) (
  input logic          clk,
  input logic          rst,
  alu_seq_unit_if.slave bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MUL_BUSY = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic [1:0]         state;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2:0]         count;

  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   result_hi_q;
  logic               carry_q;
  logic               zero_q;

  logic [WIDTH:0]     alu_wide;
  logic [WIDTH:0]     shr_wide;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_next;

  // alu_wide packs {carry, result}; SHR shifts a guard bit in below the LSB to catch the last bit out
  always_comb begin
    alu_wide = '0;
    shr_wide = {bus.opA, 1'b0} >> bus.opB[2:0];
    case (bus.opcode)
      OP_AND:  alu_wide = {1'b0, bus.opA & bus.opB};
      OP_OR:   alu_wide = {1'b0, bus.opA | bus.opB};
      OP_XOR:  alu_wide = {1'b0, bus.opA ^ bus.opB};
      OP_ADD:  alu_wide = {1'b0, bus.opA} + {1'b0, bus.opB};
      OP_SUB:  alu_wide = {1'b0, bus.opA} - {1'b0, bus.opB};
      OP_SHL:  alu_wide = {1'b0, bus.opA} << bus.opB[2:0];
      OP_SHR:  alu_wide = {shr_wide[0], shr_wide[WIDTH:1]};
      default: alu_wide = '0;
    endcase
  end

  // One shift-add step: add multiplicand into the upper half, then shift the whole accumulator right
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_next = {mul_sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      count       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (bus.opcode == OP_MUL) begin
              acc    <= '0;
              mcand  <= bus.opA;
              mplier <= bus.opB;
              count  <= '0;
              state  <= MUL_BUSY;
            end else begin
              result_q    <= alu_wide[WIDTH-1:0];
              result_hi_q <= '0;
              carry_q     <= alu_wide[WIDTH];
              zero_q      <= (alu_wide[WIDTH-1:0] == '0);
              state       <= DONE;
            end
          end
        end
        MUL_BUSY: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          count  <= count + 3'd1;
          if (count == 3'd7) begin
            result_q    <= acc_next[WIDTH-1:0];
            result_hi_q <= acc_next[2*WIDTH-1:WIDTH];
            carry_q     <= 1'b0;
            zero_q      <= (acc_next == '0);
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.res_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;

endmodule
